alu_iter: RTL
=============

Name: alu_iter

Overview:
- Parametrised, registered successor to the single-cycle core's combinational ALU.
- Adds XOR, shifts, set-less-than, status flags, and iterative unsigned multiply/divide.
- Valid/ready handshake on both sides, so a multi-cycle execute stage can stall on it.
- Sits between the register-file read stage and writeback in the multi-cycle core.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUControl  input  4  operation select.
- out_valid  output  1  Result and flags valid.
- out_ready  input  1  consumer accepts Result.
- Result  output  WIDTH  operation result.
- Zero  output  1  Result == 0.
- Negative  output  1  Result[WIDTH-1].
- Carry  output  1  carry-out (ADD), NOT borrow (SUB); else 0.
- Overflow  output  1  signed overflow (ADD/SUB); else 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, Result=0, all flags=0; state=IDLE, counter=0.
- Opcodes:
  - Single-cycle: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA. Shift amount = B[$clog2(WIDTH)-1:0].
  - Iterative: 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits), 1100 DIVU, 1101 REMU.
  - 1110, 1111: Result=0, Zero=1, other flags 0, single-cycle.
- SUB is A + ~B + 1; Carry=1 means no borrow (A >= B unsigned).
- Overflow on ADD = (A[msb]==B[msb]) && (R[msb]!=A[msb]); on SUB, B is replaced by ~B.
- Accept: handshake when in_valid && in_ready; operands and opcode are captured into internal registers.
- States:
  - IDLE: in_ready=1. Single-cycle op accepted -> DONE. Iterative op accepted -> BUSY, counter=0.
  - BUSY: in_ready=0. One shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter++. After WIDTH steps -> DONE.
  - DONE: out_valid=1; Result and flags held stable. out_ready=1 -> IDLE. in_ready=0 while in DONE.
- Latency, accept at edge N:
  - Single-cycle op: out_valid high after edge N+1.
  - Iterative op: out_valid high after edge N+WIDTH+1.
- Throughput: at most one op per 2 cycles (no accept in DONE).
- Divide by zero: DIVU -> all ones; REMU -> A. Completes in normal iterative latency, no exception.
- MULHU: computed via 2*WIDTH accumulator. DIVU/REMU: WIDTH-bit quotient and remainder registers.
- Flags for iterative ops: Zero and Negative from Result; Carry=Overflow=0.
- Inputs A, B, ALUControl may change freely after accept without affecting the operation in flight.
- Back-pressure: out_ready low in DONE holds all outputs indefinitely.
- rst mid-operation (any state): aborts the op and returns to reset values next edge. No partial result is emitted.
- in_valid while in_ready=0: ignored; the requester must hold it.

Test Plan:
- Reset: assert rst 2 cycles while in BUSY -> next cycle out_valid=0, in_ready=1, Result=0.
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, Negative=1, Carry=0; out_valid 1 cycle after accept.
- SUB: A=5, B=5 -> Result=0, Zero=1, Carry=1. SLT: A=0xFFFFFFFF, B=1 -> Result=1. SLTU, same operands -> Result=0.
- SRA: A=0x80000000, B=0x24 (shift 4) -> Result=0xF8000000.
- MUL/MULHU: A=B=0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU/REMU: A=100, B=7 -> 14 / 2. B=0 -> DIVU=0xFFFFFFFF, REMU=100. Hold out_ready=0 for 5 cycles -> Result stable, new in_valid ignored.

Source files
------------

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered ALU with valid/ready handshake and iterative unsigned multiply/divide
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           op;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  logic                 is_iter;
  logic                 is_sub;
  logic                 last_step;
  logic [SH_W-1:0]      sh;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH:0]       add_full;
  logic                 add_ovf;
  logic [WIDTH-1:0]     sc_result;
  logic                 sc_carry;
  logic                 sc_ovf;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quot_step;
  logic [WIDTH-1:0]     iter_result;

  assign is_iter   = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
  assign is_sub    = (ALUControl == OP_SUB);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign sh        = B[SH_W-1:0];

  // SUB reuses the adder as A + ~B + 1, so carry-out reads as "no borrow"
  assign b_eff    = is_sub ? ~B : B;
  assign add_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        sc_result = add_full[WIDTH-1:0];
        sc_carry  = add_full[WIDTH];
        sc_ovf    = add_ovf;
      end
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_XOR:  sc_result = A ^ B;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  sc_result = A << sh;
      OP_SRL:  sc_result = A >> sh;
      OP_SRA:  sc_result = $signed(A) >>> sh;
      default: sc_result = '0;
    endcase
  end

  // Shift-add multiply: multiplier sits in acc's low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide; a zero divisor naturally yields all-ones quotient and remainder = A
  assign div_shift = {rem, quot[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - b_reg;
  assign rem_step  = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign quot_step = {quot[WIDTH-2:0], div_ge};

  always_comb begin
    iter_result = rem_step;
    case (op)
      OP_MUL:   iter_result = acc_step[WIDTH-1:0];
      OP_MULHU: iter_result = acc_step[2*WIDTH-1:WIDTH];
      OP_DIVU:  iter_result = quot_step;
      default:  iter_result = rem_step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_iter ? BUSY : DONE;
      end
      BUSY: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      quot     <= '0;
      rem      <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= ALUControl;
            a_reg <= A;
            b_reg <= B;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, B};
            quot  <= A;
            rem   <= '0;
            if (!is_iter) begin
              Result   <= sc_result;
              Zero     <= (sc_result == '0);
              Negative <= sc_result[WIDTH-1];
              Carry    <= sc_carry;
              Overflow <= sc_ovf;
            end
          end
        end
        BUSY: begin
          cnt  <= cnt + 1'b1;
          acc  <= acc_step;
          quot <= quot_step;
          rem  <= rem_step;
          if (last_step) begin
            Result   <= iter_result;
            Zero     <= (iter_result == '0);
            Negative <= iter_result[WIDTH-1];
            Carry    <= 1'b0;
            Overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
